// File: rtl/cpu_pkg.sv
// Shared widths and enums for the memory arbiter slice: FSM states and
// requester port identifiers.
package cpu_pkg;
    localparam int AW = 5;
    localparam int DW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PORT_INS  = 2'd0,
        PORT_DAT  = 2'd1,
        PORT_HOST = 2'd2
    } port_t;
endpackage

// File: rtl/mem_arb_sel.sv
// Combinational winner selection: host first, then data, then instruction,
// with instruction promoted over data once the data streak is exhausted.
module mem_arb_sel
    import cpu_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       ins_req,
    input  logic       dat_req,
    input  logic       host_req,
    input  logic       host_lock,
    input  logic [2:0] streak,
    output logic       win_valid,
    output logic [1:0] win_id
);

    // Priority resolution; lock makes only the host eligible
    always_comb begin
        win_valid = 1'b0;
        win_id    = PORT_INS;
        if (host_req) begin
            win_valid = 1'b1;
            win_id    = PORT_HOST;
        end else if (host_lock) begin
            win_valid = 1'b0;
        end else if (ins_req && ((streak >= 3'(STARVE_MAX)) || !dat_req)) begin
            win_valid = 1'b1;
            win_id    = PORT_INS;
        end else if (dat_req) begin
            win_valid = 1'b1;
            win_id    = PORT_DAT;
        end else begin
            win_valid = 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Three-port arbiter in front of a single-port synchronous memory: one access
// at a time through IDLE -> ACCESS -> RESP.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int AW         = cpu_pkg::AW,
    parameter int DW         = cpu_pkg::DW,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ins_req,
    input  logic [AW-1:0] ins_addr,
    input  logic          dat_req,
    input  logic          dat_we,
    input  logic [AW-1:0] dat_addr,
    input  logic [DW-1:0] dat_wdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_lock,
    output logic          ins_gnt,
    output logic          dat_gnt,
    output logic          host_gnt,
    output logic          ins_rvalid,
    output logic          dat_rvalid,
    output logic          host_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    state_t        state_r;
    logic [1:0]    cap_id_r;
    logic [AW-1:0] cap_addr_r;
    logic [DW-1:0] cap_wdata_r;
    logic [DW-1:0] rdata_hold_r;
    logic [2:0]    streak_r;

    logic          win_valid_s;
    logic [1:0]    win_id_s;
    logic          sel_we_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;
    logic [2:0]    streak_nxt_s;

    mem_arb_sel #(.STARVE_MAX(STARVE_MAX)) u_sel (
        .ins_req   (ins_req),
        .dat_req   (dat_req),
        .host_req  (host_req),
        .host_lock (host_lock),
        .streak    (streak_r),
        .win_valid (win_valid_s),
        .win_id    (win_id_s)
    );

    // Command fields of the current winner
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        case (win_id_s)
            PORT_HOST: begin
                sel_we_s    = host_we;
                sel_addr_s  = host_addr;
                sel_wdata_s = host_wdata;
            end
            PORT_DAT: begin
                sel_we_s    = dat_we;
                sel_addr_s  = dat_addr;
                sel_wdata_s = dat_wdata;
            end
            PORT_INS: begin
                sel_we_s    = 1'b0;
                sel_addr_s  = ins_addr;
                sel_wdata_s = '0;
            end
            default: begin
                sel_we_s    = 1'b0;
                sel_addr_s  = '0;
                sel_wdata_s = '0;
            end
        endcase
    end

    // Data streak: frozen under lock or host grant, counts data wins over a waiting fetch
    always_comb begin
        streak_nxt_s = streak_r;
        if (host_lock || (win_valid_s && (win_id_s == PORT_HOST))) begin
            streak_nxt_s = streak_r;
        end else if (win_valid_s && (win_id_s == PORT_INS)) begin
            streak_nxt_s = 3'd0;
        end else if (win_valid_s && (win_id_s == PORT_DAT) && ins_req) begin
            streak_nxt_s = (streak_r == 3'd7) ? streak_r : streak_r + 3'd1;
        end else if (!ins_req) begin
            streak_nxt_s = 3'd0;
        end else begin
            streak_nxt_s = streak_r;
        end
    end

    // Access FSM with capture registers and registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cap_id_r     <= PORT_INS;
            cap_addr_r   <= '0;
            cap_wdata_r  <= '0;
            rdata_hold_r <= '0;
            streak_r     <= 3'd0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            ins_gnt      <= 1'b0;
            dat_gnt      <= 1'b0;
            host_gnt     <= 1'b0;
            ins_rvalid   <= 1'b0;
            dat_rvalid   <= 1'b0;
            host_rvalid  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    streak_r <= streak_nxt_s;
                    if (win_valid_s) begin
                        state_r     <= ACCESS;
                        cap_id_r    <= win_id_s;
                        cap_addr_r  <= sel_addr_s;
                        cap_wdata_r <= sel_wdata_s;
                        mem_en      <= 1'b1;
                        mem_we      <= sel_we_s;
                        ins_gnt     <= (win_id_s == PORT_INS);
                        dat_gnt     <= (win_id_s == PORT_DAT);
                        host_gnt    <= (win_id_s == PORT_HOST);
                    end
                end
                ACCESS: begin
                    state_r     <= RESP;
                    mem_en      <= 1'b0;
                    mem_we      <= 1'b0;
                    ins_gnt     <= 1'b0;
                    dat_gnt     <= 1'b0;
                    host_gnt    <= 1'b0;
                    ins_rvalid  <= (cap_id_r == PORT_INS);
                    dat_rvalid  <= (cap_id_r == PORT_DAT);
                    host_rvalid <= (cap_id_r == PORT_HOST);
                end
                RESP: begin
                    state_r      <= IDLE;
                    rdata_hold_r <= mem_rdata;
                    ins_rvalid   <= 1'b0;
                    dat_rvalid   <= 1'b0;
                    host_rvalid  <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    mem_en      <= 1'b0;
                    mem_we      <= 1'b0;
                    ins_gnt     <= 1'b0;
                    dat_gnt     <= 1'b0;
                    host_gnt    <= 1'b0;
                    ins_rvalid  <= 1'b0;
                    dat_rvalid  <= 1'b0;
                    host_rvalid <= 1'b0;
                end
            endcase
        end
    end

    // Memory data arrives in RESP, so rdata passes it straight through there
    assign rdata     = (state_r == RESP) ? mem_rdata : rdata_hold_r;
    assign mem_addr  = cap_addr_r;
    assign mem_wdata = cap_wdata_r;
    assign busy      = (state_r != IDLE);

endmodule
